bram_sd_seq: RTL and testbench
==============================

# bram_sd_seq

Backup-RAM save/load sequencer for the Genesis core. It moves the cartridge save RAM between the `system` BRAM port and the mounted save image, one 512-byte sector at a time, over the hps_io `sd_lba`/`sd_rd`/`sd_wr`/`sd_ack` handshake. It handles four jobs:
- arming save support after a ROM download;
- auto-loading the save after a ROM download;
- manual load and save from the OSD;
- autosave when the OSD opens.

It sits between `hps_io` and `system` inside `emu`. It also drives the core reset while a load is in progress.

## Interface
Parameters:
- `SECTORS`, default 128: sectors per transfer; power of two, minimum 2.
- `LBA_W`, default 32: width of `sd_lba`.

Ports:
- `clk_sys`, in, 1: system clock.
- `reset`, in, 1: power-on reset. Synchronous, active-high. It must not be driven from the core reset, because `bk_loading` feeds the core reset.
- `downloading`, in, 1: ROM download in progress.
- `img_mounted`, in, 1: pulse, save image mounted.
- `img_readonly`, in, 1: mounted image is read-only.
- `img_size`, in, 64: mounted image size in bytes.
- `osd_status`, in, 1: OSD open.
- `autosave_en`, in, 1: autosave option.
- `load_req`, in, 1: OSD "Load Backup RAM" level; acts on its rising edge.
- `save_req`, in, 1: OSD "Save Backup RAM" level; acts on its rising edge.
- `bram_change`, in, 1: pulse, the game wrote BRAM.
- `sd_ack`, in, 1: hps_io sector acknowledge.
- `sd_lba`, out, `LBA_W`: current sector.
- `sd_rd`, out, 1: sector read request.
- `sd_wr`, out, 1: sector write request.
- `bk_ena`, out, 1: save support armed; selects the OSD menu visibility.
- `bk_loading`, out, 1: load in progress; ORed into the core reset.
- `busy`, out, 1: transfer in progress.
- `sav_pending`, out, 1: unsaved BRAM changes; drives the LED.
- `done`, out, 1: one-cycle pulse when a transfer completes.

## Operation
- **Arming.**
  - Rising edge of `downloading` clears `bk_ena`.
  - `bk_ena` is set in any cycle where `downloading & img_mounted & (img_size != 0) & ~img_readonly`.
- **Triggers.** Edge detectors register `downloading`, `load_req`, `save_req`, the autosave term and `sd_ack`.
  - Autoload fires on the falling edge of `downloading` when `bk_ena` = 1.
  - Load fires on the rising edge of `load_req` when `bk_ena` = 1.
  - Save fires on the rising edge of `save_req`, or on the rising edge of the autosave term, when `bk_ena` = 1. The autosave term is `sav_pending & osd_status & autosave_en`.
  - Triggers are accepted only in IDLE. Triggers arriving while busy are dropped, not queued.
  - If several triggers fire in the same cycle, priority is autoload > load > save.
- **FSM states:** IDLE, REQ, XFER.
  - IDLE → REQ on an accepted trigger:
    - `sd_lba` ← 0;
    - `bk_loading` ← 1 for a load, 0 for a save;
    - `sd_rd` ← load;
    - `sd_wr` ← ~load.
  - REQ → XFER on the rising edge of `sd_ack`: `sd_rd` and `sd_wr` ← 0.
  - XFER on the falling edge of `sd_ack`:
    - if `sd_lba` = `SECTORS-1`: go to IDLE, `bk_loading` ← 0, pulse `done`;
    - otherwise: `sd_lba` ← `sd_lba` + 1, re-assert `sd_rd`/`sd_wr` according to `bk_loading`, go to REQ.
- **`busy`** = (state != IDLE).
- **Sector counter.** The counter is $clog2(`SECTORS`) bits, zero-extended onto `sd_lba`; it cannot wrap past `SECTORS-1`. The BRAM address is `{sd_lba[$clog2(SECTORS)-1:0], sd_buff_addr}`, formed outside this block.
- **`sav_pending`.**
  - Set by `bram_change & ~osd_status`.
  - Cleared in the cycle a save or load is accepted.
  - If a set and a clear happen in the same cycle, set wins.
- **Mid-transfer conditions.**
  - `reset` mid-transfer: FSM → IDLE and every output goes to its reset value.
  - `downloading` rising mid-transfer: clears `bk_ena` only. The current transfer runs to completion.

## Timing
- **Reset values:**
  - `sd_lba` = 0;
  - `sd_rd`, `sd_wr`, `bk_ena`, `bk_loading`, `busy`, `sav_pending`, `done` = 0;
  - state = IDLE;
  - all edge-detector history registers = 0.
- All outputs are registered.
- **Trigger latency.** A trigger input level changes at edge N and is sampled at edge N+1. `sd_rd`/`sd_wr`, `busy` and `bk_loading` assert after edge N+1.
- **Request drop.** `sd_rd`/`sd_wr` drop one cycle after `sd_ack` is seen high.
- **Next-sector request.** The next request asserts one cycle after `sd_ack` is seen low.
- **`done`.** Pulses for exactly one cycle, in the cycle after the final falling edge of `sd_ack`. `busy` and `bk_loading` fall in that same cycle.
- **No timeout.** A stuck `sd_ack` holds the FSM indefinitely.
- `sd_ack` already high on entry to REQ is not an edge; the FSM waits for a fresh rise.

## Structure
- Package `bram_seq_pkg`:
  - the `bk_state_t` enum (IDLE, REQ, XFER);
  - localparam `SECTOR_BYTES` = 512.
- Single module; no sub-module. Edge detection is done inline.

## Test plan
- **Autoload:** power-on reset, then `downloading` 1 with an `img_mounted` pulse (`img_size` = 65536, `img_readonly` = 0), then `downloading` 0 → `bk_ena` = 1. Expect 128 reads at `sd_lba` 0..127 with `sd_wr` never high, `bk_loading` high throughout, then `done`.
- **Read-only image:** as autoload but `img_readonly` = 1 → `bk_ena` stays 0. No `sd_rd` after the download ends, and a `load_req` rise is ignored.
- **Autosave:** `bk_ena` = 1, `autosave_en` = 1, `osd_status` = 0, one `bram_change` pulse → `sav_pending` = 1. Raising `osd_status` starts 128 writes, and `sav_pending` clears in the accept cycle.
- **Collision:** `load_req` and `save_req` rise in the same cycle → a load is performed. A further `save_req` rise during that transfer is dropped; exactly 128 handshakes occur.
- **Handshake latency:** with `sd_ack` delayed 5 cycles per phase, `sd_rd` drops exactly 1 cycle after the ack rise, and `sd_lba` increments 1 cycle after the ack fall.
- **Reset mid-transfer:** reset at sector 37 → next cycle `sd_rd` = `sd_wr` = 0, `busy` = 0, `bk_ena` = 0, `sd_lba` = 0, and no `done` pulse.

Source files
------------

// File: rtl/bram_seq_pkg.sv
// rtl/bram_seq_pkg.sv - shared types and constants for the backup-RAM sequencer
// Contents: bk_state_t (sequencer FSM states), SECTOR_BYTES (bytes per sd sector).
package bram_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } bk_state_t;

  localparam int SECTOR_BYTES = 512;

endpackage

// File: rtl/bram_sd_seq.sv
// rtl/bram_sd_seq.sv - backup-RAM save/load sector sequencer over the hps_io sd handshake
// Ports:
//   clk_sys, reset (sync, active-high, power-on only)
//   downloading, img_mounted, img_readonly, img_size : ROM download / image mount status
//   osd_status, autosave_en, load_req, save_req       : OSD controls
//   bram_change                                       : game wrote BRAM
//   sd_ack / sd_lba, sd_rd, sd_wr                     : hps_io sector handshake
//   bk_ena, bk_loading, busy, sav_pending, done       : status outputs (all registered)
module bram_sd_seq
  import bram_seq_pkg::*;
#(
  parameter int SECTORS = 128,
  parameter int LBA_W   = 32
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             downloading,
  input  logic             img_mounted,
  input  logic             img_readonly,
  input  logic [63:0]      img_size,
  input  logic             osd_status,
  input  logic             autosave_en,
  input  logic             load_req,
  input  logic             save_req,
  input  logic             bram_change,
  input  logic             sd_ack,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  output logic             bk_ena,
  output logic             bk_loading,
  output logic             busy,
  output logic             sav_pending,
  output logic             done
);

  localparam int CW = $clog2(SECTORS);
  localparam logic [CW-1:0] LAST_SECTOR = CW'(SECTORS - 1);

  bk_state_t     state_q, state_d;
  logic [CW-1:0] lba_q, lba_d;
  logic          sd_rd_q, sd_rd_d;
  logic          sd_wr_q, sd_wr_d;
  logic          bk_ena_q, bk_ena_d;
  logic          bk_loading_q, bk_loading_d;
  logic          busy_q, busy_d;
  logic          sav_pending_q, sav_pending_d;
  logic          done_q, done_d;

  // Edge-detector history
  logic          dl_q, dl_d;
  logic          load_q, load_d;
  logic          save_q, save_d;
  logic          auto_q, auto_d;
  logic          ack_q, ack_d;

  logic          auto_term;
  logic          trig_autoload, trig_load, trig_save;
  logic          ack_rise, ack_fall;
  logic          accept, is_load;

  always_comb begin
    state_d       = state_q;
    lba_d         = lba_q;
    sd_rd_d       = sd_rd_q;
    sd_wr_d       = sd_wr_q;
    bk_ena_d      = bk_ena_q;
    bk_loading_d  = bk_loading_q;
    sav_pending_d = sav_pending_q;
    done_d        = 1'b0;
    accept        = 1'b0;
    is_load       = 1'b0;

    auto_term = sav_pending_q & osd_status & autosave_en;

    dl_d   = downloading;
    load_d = load_req;
    save_d = save_req;
    auto_d = auto_term;
    ack_d  = sd_ack;

    ack_rise = sd_ack & ~ack_q;
    ack_fall = ~sd_ack & ack_q;

    trig_autoload = ~downloading & dl_q & bk_ena_q;
    trig_load     = load_req & ~load_q & bk_ena_q;
    trig_save     = ((save_req & ~save_q) | (auto_term & ~auto_q)) & bk_ena_q;

    // A new download disarms; a writable non-empty image mounted during it re-arms.
    if (downloading & ~dl_q) bk_ena_d = 1'b0;
    if (downloading & img_mounted & (img_size != 64'd0) & ~img_readonly) bk_ena_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (trig_autoload | trig_load | trig_save) begin
          accept       = 1'b1;
          is_load      = trig_autoload | trig_load;  // load outranks save
          state_d      = REQ;
          lba_d        = '0;
          bk_loading_d = is_load;
          sd_rd_d      = is_load;
          sd_wr_d      = ~is_load;
        end
      end
      REQ: begin
        if (ack_rise) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (ack_fall) begin
          if (lba_q == LAST_SECTOR) begin
            state_d      = IDLE;
            bk_loading_d = 1'b0;
            done_d       = 1'b1;
          end else begin
            lba_d   = lba_q + 1'b1;
            sd_rd_d = bk_loading_q;
            sd_wr_d = ~bk_loading_q;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear on accept first so a same-cycle change still leaves the LED lit.
    if (accept) sav_pending_d = 1'b0;
    if (bram_change & ~osd_status) sav_pending_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= IDLE;
      lba_q         <= '0;
      sd_rd_q       <= 1'b0;
      sd_wr_q       <= 1'b0;
      bk_ena_q      <= 1'b0;
      bk_loading_q  <= 1'b0;
      busy_q        <= 1'b0;
      sav_pending_q <= 1'b0;
      done_q        <= 1'b0;
      dl_q          <= 1'b0;
      load_q        <= 1'b0;
      save_q        <= 1'b0;
      auto_q        <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      lba_q         <= lba_d;
      sd_rd_q       <= sd_rd_d;
      sd_wr_q       <= sd_wr_d;
      bk_ena_q      <= bk_ena_d;
      bk_loading_q  <= bk_loading_d;
      busy_q        <= busy_d;
      sav_pending_q <= sav_pending_d;
      done_q        <= done_d;
      dl_q          <= dl_d;
      load_q        <= load_d;
      save_q        <= save_d;
      auto_q        <= auto_d;
      ack_q         <= ack_d;
    end
  end

  assign sd_lba      = LBA_W'(lba_q);
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign bk_ena      = bk_ena_q;
  assign bk_loading  = bk_loading_q;
  assign busy        = busy_q;
  assign sav_pending = sav_pending_q;
  assign done        = done_q;

endmodule

// File: tb/tb_bram_sd_seq.sv
// tb/tb_bram_sd_seq.sv - scoreboard testbench for bram_sd_seq
module tb_bram_sd_seq;

  localparam int SECTORS = 128;
  localparam int LBA_W   = 32;
  localparam int BUDGET  = 20000;

  logic             clk_sys = 1'b0;
  logic             reset;
  logic             downloading, img_mounted, img_readonly;
  logic [63:0]      img_size;
  logic             osd_status, autosave_en, load_req, save_req, bram_change;
  logic             sd_ack;
  logic [LBA_W-1:0] sd_lba;
  logic             sd_rd, sd_wr, bk_ena, bk_loading, busy, sav_pending, done;

  bram_sd_seq #(.SECTORS(SECTORS), .LBA_W(LBA_W)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .downloading(downloading), .img_mounted(img_mounted), .img_readonly(img_readonly),
    .img_size(img_size), .osd_status(osd_status), .autosave_en(autosave_en),
    .load_req(load_req), .save_req(save_req), .bram_change(bram_change),
    .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .bk_ena(bk_ena), .bk_loading(bk_loading), .busy(busy),
    .sav_pending(sav_pending), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit is_done;
    bit rd;
    int lba;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   hs_cnt = 0;
  int   ack_dly = 2;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transfer is SECTORS requests at lba 0..SECTORS-1 followed by done.
  task automatic push_xfer(input bit load);
    exp_t e;
    for (int i = 0; i < SECTORS; i++) begin
      e.is_done = 1'b0; e.rd = load; e.lba = i;
      exp_q.push_back(e);
    end
    e.is_done = 1'b1; e.rd = load; e.lba = SECTORS - 1;
    exp_q.push_back(e);
  endtask

  // Monitor: pops expected events whenever the DUT presents a request or done.
  bit   prev_req = 1'b0;
  bit   cur_req;
  exp_t m_e;
  always @(negedge clk_sys) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      cur_req = sd_rd | sd_wr;
      if (cur_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_req actual=rd%0d/wr%0d lba=%0d expected=none", sd_rd, sd_wr, sd_lba);
        end else begin
          m_e = exp_q.pop_front();
          chk("req_kind", 0, m_e.is_done);
          chk("req_rd", sd_rd, m_e.rd);
          chk("req_wr", sd_wr, !m_e.rd);
          chk("req_lba", sd_lba, m_e.lba);
          chk("req_loading", bk_loading, m_e.rd);
          chk("req_busy", busy, 1);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          m_e = exp_q.pop_front();
          chk("done_kind", 1, m_e.is_done);
          chk("done_busy", busy, 0);
          chk("done_loading", bk_loading, 0);
        end
        done_cnt++;
      end
      prev_req = cur_req;
    end
  end

  // hps_io responder: acks each request after ack_dly cycles and checks handshake latency.
  int rs = 0;
  int rcnt = 0;
  int old_lba = 0;
  always @(negedge clk_sys) begin
    if (reset) begin
      sd_ack = 1'b0;
      rs = 0;
    end else begin
      case (rs)
        0: if (sd_rd | sd_wr) begin rcnt = ack_dly; rs = 1; end
        1: if (rcnt == 0) begin sd_ack = 1'b1; hs_cnt++; rs = 2; end else rcnt--;
        2: begin
          chk("req_drop_1cyc", sd_rd | sd_wr, 0);
          rcnt = ack_dly; rs = 3;
        end
        3: if (rcnt == 0) begin sd_ack = 1'b0; old_lba = int'(sd_lba); rs = 4; end else rcnt--;
        default: begin
          if (old_lba == SECTORS - 1) begin
            chk("done_after_last_fall", done, 1);
            rs = 0;
          end else begin
            chk("next_req_1cyc", sd_rd | sd_wr, 1);
            chk("lba_inc_1cyc", sd_lba, old_lba + 1);
            if (sd_rd | sd_wr) begin rcnt = ack_dly; rs = 1; end else rs = 0;
          end
        end
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_done(input string name);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < BUDGET) begin
      @(negedge clk_sys);
      n++;
    end
    chk({name, "_done_seen"}, done_cnt > start, 1);
    @(negedge clk_sys);
    chk({name, "_done_1cyc"}, done, 0);
    chk({name, "_idle"}, busy, 0);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // ROM download with an image mount; returns whether the model expects arming.
  task automatic do_download(input bit ro, input logic [63:0] size, output bit armed);
    armed = !ro && (size != 64'd0);
    downloading = 1'b1;
    tick(1);
    chk("dl_rise_clears_ena", bk_ena, 0);
    img_mounted = 1'b1; img_readonly = ro; img_size = size;
    tick(1);
    img_mounted = 1'b0;
    tick(2);
    chk("arm_state", bk_ena, armed);
    if (armed) push_xfer(1'b1);
    ack_dly = $urandom_range(0, 4);
    downloading = 1'b0;
    tick(2);
    chk("autoload_started", busy, armed);
    if (armed) begin
      chk("autoload_loading", bk_loading, 1);
      wait_done("autoload");
      chk("still_armed", bk_ena, 1);
    end
  endtask

  bit armed;
  int d0;
  int n;

  initial begin
    reset = 1'b1;
    downloading = 0; img_mounted = 0; img_readonly = 0; img_size = 64'd0;
    osd_status = 0; autosave_en = 0; load_req = 0; save_req = 0; bram_change = 0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_lba", sd_lba, 0);
    chk("rst_rd", sd_rd, 0);
    chk("rst_wr", sd_wr, 0);
    chk("rst_bk_ena", bk_ena, 0);
    chk("rst_loading", bk_loading, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sav_pending", sav_pending, 0);
    chk("rst_done", done, 0);

    // Autoload from a 64 KiB writable image
    do_download(1'b0, 64'd65536, armed);

    // Read-only image: disarmed, and load requests are ignored
    do_download(1'b1, 64'd65536, armed);
    load_req = 1'b1;
    tick(5);
    chk("ro_load_ignored", busy, 0);
    chk("ro_no_rd", sd_rd, 0);
    load_req = 1'b0;
    tick(1);

    // Empty image does not arm
    do_download(1'b0, 64'd0, armed);

    // Re-arm with a random nonzero image size
    do_download(1'b0, 64'($urandom_range(1, 1 << 20)), armed);

    // Autosave on OSD open
    autosave_en = 1'b1;
    bram_change = 1'b1;
    tick(1);
    bram_change = 1'b0;
    tick(1);
    chk("sav_pending_set", sav_pending, 1);
    ack_dly = $urandom_range(0, 4);
    push_xfer(1'b0);
    osd_status = 1'b1;
    tick(1);
    chk("autosave_accept_clears", sav_pending, 0);
    chk("autosave_busy", busy, 1);
    chk("autosave_wr", sd_wr, 1);
    wait_done("autosave");
    bram_change = 1'b1;
    tick(1);
    bram_change = 1'b0;
    tick(1);
    chk("change_in_osd_ignored", sav_pending, 0);
    osd_status = 1'b0;
    autosave_en = 1'b0;
    tick(2);

    // Collision: load wins, a later save rise is dropped
    ack_dly = $urandom_range(0, 3);
    d0 = hs_cnt;
    push_xfer(1'b1);
    load_req = 1'b1;
    save_req = 1'b1;
    tick(10);
    save_req = 1'b0;
    tick(3);
    save_req = 1'b1;
    tick(2);
    wait_done("collision");
    chk("collision_handshakes", hs_cnt - d0, SECTORS);
    tick(10);
    chk("collision_save_dropped", busy, 0);
    load_req = 1'b0;
    save_req = 1'b0;
    tick(2);

    // Fixed 5-cycle ack latency save; bram_change in the accept cycle keeps sav_pending set
    ack_dly = 5;
    push_xfer(1'b0);
    bram_change = 1'b1;
    save_req = 1'b1;
    tick(1);
    bram_change = 1'b0;
    chk("set_wins_over_clear", sav_pending, 1);
    chk("save_busy", busy, 1);
    chk("save_wr", sd_wr, 1);
    wait_done("latency_save");
    chk("sav_pending_kept", sav_pending, 1);
    save_req = 1'b0;
    tick(2);

    // Reset in the middle of a load at sector 37
    ack_dly = $urandom_range(1, 3);
    push_xfer(1'b1);
    load_req = 1'b1;
    n = 0;
    while (sd_lba != 37 && n < BUDGET) begin
      @(negedge clk_sys);
      n++;
    end
    chk("reached_sector_37", sd_lba, 37);
    reset = 1'b1;
    load_req = 1'b0;
    exp_q.delete();
    d0 = done_cnt;
    tick(1);
    chk("midrst_rd", sd_rd, 0);
    chk("midrst_wr", sd_wr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_bk_ena", bk_ena, 0);
    chk("midrst_lba", sd_lba, 0);
    chk("midrst_loading", bk_loading, 0);
    chk("midrst_sav_pending", sav_pending, 0);
    tick(1);
    reset = 1'b0;
    tick(40);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_stays_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
